// File: rtl/io_port_regs_if.sv
// Host port bus between the Z80-side port demux (master) and io_port_regs (slave).
interface io_port_regs_if;
  logic [0:255][7:0] WRITE_PORT_DATA;
  logic [0:255]      WRITE_PORT_STROBE;
  logic [7:0]        READ_PORT_ADDR;
  logic              READ_PORT_STROBE;
  logic [7:0]        READ_PORT_DATA;
  logic              READ_PORT_VALID;

  modport master (
    output WRITE_PORT_DATA, WRITE_PORT_STROBE, READ_PORT_ADDR, READ_PORT_STROBE,
    input  READ_PORT_DATA, READ_PORT_VALID
  );

  modport slave (
    input  WRITE_PORT_DATA, WRITE_PORT_STROBE, READ_PORT_ADDR, READ_PORT_STROBE,
    output READ_PORT_DATA, READ_PORT_VALID
  );
endinterface

// File: rtl/io_port_regs.sv
// Host I/O register bank: MMU banks, GPU DDR3 window and SD argument/trigger registers.
// Optional read-back path enabled by defining IO_READBACK_EN.
module io_port_regs #(
  parameter int         MMU_BANKS     = 4,
  parameter logic [7:0] MMU_BASE      = 8'h38,
  parameter int         GPU_MMU_BYTES = 2,
  parameter logic [7:0] GPU_BASE      = 8'hFC,
  parameter int         SD_ARG_BYTES  = 4,
  parameter logic [7:0] SD_BASE       = 8'hF0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  io_port_regs_if.slave                     port,
  input  logic                              SD_busy,
  output logic [0:MMU_BANKS-1][7:0]         MMU_AREA,
  output logic [7:0]                        MMU_ENABLE,
  output logic [0:GPU_MMU_BYTES-1][7:0]     GPU_MMU,
  output logic [$clog2(SD_ARG_BYTES)-1:0]   ARG_PTR,
  output logic [8*SD_ARG_BYTES-1:0]         SD_sector,
  output logic [1:0]                        SD_wr_ena,
  output logic                              SD_op_ena,
  output logic                              SD_pending,
  output logic                              SD_overrun
);

  localparam int         PW          = $clog2(SD_ARG_BYTES);
  localparam logic [7:0] MMU_EN_PORT = MMU_BASE + 8'(MMU_BANKS);
  localparam logic [7:0] SD_STATUS   = SD_BASE;
  localparam logic [7:0] SD_SECTOR   = SD_BASE + 8'd1;
  localparam logic [7:0] SD_MODE     = SD_BASE + 8'd2;
  localparam logic [7:0] SD_ARGP     = SD_BASE + 8'd3;

  logic [0:MMU_BANKS-1][7:0]     mmu_area_q, mmu_area_d;
  logic [7:0]                    mmu_enable_q, mmu_enable_d;
  logic [0:GPU_MMU_BYTES-1][7:0] gpu_mmu_q, gpu_mmu_d;
  logic [PW-1:0]                 arg_ptr_q, arg_ptr_d, arg_ptr_inc;
  logic [8*SD_ARG_BYTES-1:0]     sd_sector_q, sd_sector_d;
  logic [1:0]                    sd_wr_ena_q, sd_wr_ena_d;
  logic                          sd_op_ena_q, sd_op_ena_d;
  logic                          sd_pending_q, sd_pending_d;
  logic                          sd_overrun_q, sd_overrun_d;

  logic wr_status, wr_sector, wr_mode, wr_argp, rd_sector, sd_free;
  logic [7:0] status_data, sector_data, mode_data, argp_data;

  assign wr_status   = port.WRITE_PORT_STROBE[SD_STATUS];
  assign wr_sector   = port.WRITE_PORT_STROBE[SD_SECTOR];
  assign wr_mode     = port.WRITE_PORT_STROBE[SD_MODE];
  assign wr_argp     = port.WRITE_PORT_STROBE[SD_ARGP];
  assign status_data = port.WRITE_PORT_DATA[SD_STATUS];
  assign sector_data = port.WRITE_PORT_DATA[SD_SECTOR];
  assign mode_data   = port.WRITE_PORT_DATA[SD_MODE];
  assign argp_data   = port.WRITE_PORT_DATA[SD_ARGP];

  // A request issues only when nothing is queued and no pulse is in flight.
  assign sd_free     = !SD_busy && !sd_pending_q && !sd_op_ena_q;
  assign arg_ptr_inc = (32'(arg_ptr_q) >= SD_ARG_BYTES - 1) ? '0 : arg_ptr_q + 1'b1;

  // Host-visible registers: every port has its own strobe decode, no priority chain.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    mmu_area_d   = mmu_area_q;
    mmu_enable_d = mmu_enable_q;
    gpu_mmu_d    = gpu_mmu_q;
    arg_ptr_d    = arg_ptr_q;
    sd_sector_d  = sd_sector_q;
    for (int i = 0; i < MMU_BANKS; i++) begin
      if (port.WRITE_PORT_STROBE[MMU_BASE + 8'(i)]) mmu_area_d[i] = port.WRITE_PORT_DATA[MMU_BASE + 8'(i)];
    end
    if (port.WRITE_PORT_STROBE[MMU_EN_PORT]) mmu_enable_d = port.WRITE_PORT_DATA[MMU_EN_PORT];
    for (int i = 0; i < GPU_MMU_BYTES; i++) begin
      if (port.WRITE_PORT_STROBE[GPU_BASE + 8'(i)]) gpu_mmu_d[i] = port.WRITE_PORT_DATA[GPU_BASE + 8'(i)];
    end
    if (wr_sector && (32'(arg_ptr_q) < SD_ARG_BYTES)) sd_sector_d[32'(arg_ptr_q)*8 +: 8] = sector_data;
    // The sector byte lands at the old pointer; an ARG_PTR write wins the pointer update.
    if (wr_argp) arg_ptr_d = argp_data[PW-1:0];
    else if (wr_sector || rd_sector) arg_ptr_d = arg_ptr_inc;
  end

  always_comb begin
    sd_wr_ena_d  = sd_wr_ena_q;
    sd_op_ena_d  = 1'b0;
    sd_pending_d = sd_pending_q;
    sd_overrun_d = sd_overrun_q;
    if (wr_status && status_data[2]) sd_overrun_d = 1'b0;
    // A MODE write either issues now or queues; a fresh overrun beats the clear above.
    if (wr_mode) begin
      sd_wr_ena_d = mode_data[1:0];
      if (sd_free) begin
        sd_op_ena_d = 1'b1;
      end else begin
        sd_pending_d = 1'b1;
        if (sd_pending_q) sd_overrun_d = 1'b1;
      end
    end else if (sd_pending_q && !SD_busy && !sd_op_ena_q) begin
      sd_op_ena_d  = 1'b1;
      sd_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MMU_BANKS; i++) mmu_area_q[i] <= (i == 0) ? 8'hFF : 8'(i);
      mmu_enable_q <= '0;
      gpu_mmu_q    <= '0;
      arg_ptr_q    <= '0;
      sd_sector_q  <= '0;
      sd_wr_ena_q  <= '0;
      sd_op_ena_q  <= 1'b0;
      sd_pending_q <= 1'b0;
      sd_overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      mmu_area_q   <= mmu_area_d;
      mmu_enable_q <= mmu_enable_d;
      gpu_mmu_q    <= gpu_mmu_d;
      arg_ptr_q    <= arg_ptr_d;
      sd_sector_q  <= sd_sector_d;
      sd_wr_ena_q  <= sd_wr_ena_d;
      sd_op_ena_q  <= sd_op_ena_d;
      sd_pending_q <= sd_pending_d;
      sd_overrun_q <= sd_overrun_d;
    end
  end

`ifdef IO_READBACK_EN
  logic [7:0] rd_mux, rd_data_q;
  logic       rd_valid_q;

  assign rd_sector = port.READ_PORT_STROBE && (port.READ_PORT_ADDR == SD_SECTOR);

  always_comb begin
    rd_mux = 8'hFF;
    for (int i = 0; i < MMU_BANKS; i++) begin
      if (port.READ_PORT_ADDR == MMU_BASE + 8'(i)) rd_mux = mmu_area_q[i];
    end
    if (port.READ_PORT_ADDR == MMU_EN_PORT) rd_mux = mmu_enable_q;
    for (int i = 0; i < GPU_MMU_BYTES; i++) begin
      if (port.READ_PORT_ADDR == GPU_BASE + 8'(i)) rd_mux = gpu_mmu_q[i];
    end
    if (port.READ_PORT_ADDR == SD_STATUS) rd_mux = {5'b0, sd_overrun_q, sd_pending_q, SD_busy};
    if (port.READ_PORT_ADDR == SD_SECTOR) begin
      rd_mux = (32'(arg_ptr_q) < SD_ARG_BYTES) ? sd_sector_q[32'(arg_ptr_q)*8 +: 8] : 8'hFF;
    end
    if (port.READ_PORT_ADDR == SD_MODE) rd_mux = {6'b0, sd_wr_ena_q};
    if (port.READ_PORT_ADDR == SD_ARGP) rd_mux = 8'(arg_ptr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= port.READ_PORT_STROBE;
      if (port.READ_PORT_STROBE) rd_data_q <= rd_mux;
    end
  end

  assign port.READ_PORT_DATA  = rd_data_q;
  assign port.READ_PORT_VALID = rd_valid_q;
`else
  assign rd_sector            = 1'b0;
  assign port.READ_PORT_DATA  = '0;
  assign port.READ_PORT_VALID = 1'b0;
`endif

  assign MMU_AREA   = mmu_area_q;
  assign MMU_ENABLE = mmu_enable_q;
  assign GPU_MMU    = gpu_mmu_q;
  assign ARG_PTR    = arg_ptr_q;
  assign SD_sector  = sd_sector_q;
  assign SD_wr_ena  = sd_wr_ena_q;
  assign SD_op_ena  = sd_op_ena_q;
  assign SD_pending = sd_pending_q;
  assign SD_overrun = sd_overrun_q;

endmodule

// File: tb/tb_io_port_regs.sv
// Self-checking bench for io_port_regs: behavioural register model plus literal checks.
module tb_io_port_regs;
  localparam int         MMU_BANKS = 4;
  localparam int         GPU_BYTES = 2;
  localparam int         ARG_BYTES = 4;
  localparam logic [7:0] SD_STATUS = 8'hF0;
  localparam logic [7:0] SD_SECTOR = 8'hF1;
  localparam logic [7:0] SD_MODE   = 8'hF2;
  localparam logic [7:0] SD_ARGP   = 8'hF3;
`ifdef IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic sd_busy;
  logic [0:MMU_BANKS-1][7:0] mmu_area;
  logic [7:0]                mmu_enable;
  logic [0:GPU_BYTES-1][7:0] gpu_mmu;
  logic [1:0]                arg_ptr;
  logic [31:0]               sd_sector;
  logic [1:0]                sd_wr_ena;
  logic                      sd_op_ena, sd_pending, sd_overrun;

  io_port_regs_if bus();

  io_port_regs #(
    .MMU_BANKS(MMU_BANKS), .MMU_BASE(8'h38), .GPU_MMU_BYTES(GPU_BYTES),
    .GPU_BASE(8'hFC), .SD_ARG_BYTES(ARG_BYTES), .SD_BASE(8'hF0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port(bus.slave), .SD_busy(sd_busy),
    .MMU_AREA(mmu_area), .MMU_ENABLE(mmu_enable), .GPU_MMU(gpu_mmu),
    .ARG_PTR(arg_ptr), .SD_sector(sd_sector), .SD_wr_ena(sd_wr_ena),
    .SD_op_ena(sd_op_ena), .SD_pending(sd_pending), .SD_overrun(sd_overrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the register bank, one step per clock edge.
  int m_mmu[MMU_BANKS];
  int m_en, m_ptr, m_mode, m_rdata;
  int m_gpu[GPU_BYTES];
  int m_sec[ARG_BYTES];
  bit m_pend, m_ovr, m_op, m_rvalid;

  task automatic m_reset();
    for (int i = 0; i < MMU_BANKS; i++) m_mmu[i] = (i == 0) ? 255 : i;
    for (int i = 0; i < GPU_BYTES; i++) m_gpu[i] = 0;
    for (int i = 0; i < ARG_BYTES; i++) m_sec[i] = 0;
    m_en = 0; m_ptr = 0; m_mode = 0; m_rdata = 0;
    m_pend = 0; m_ovr = 0; m_op = 0; m_rvalid = 0;
  endtask

  function automatic int m_read(input int a);
    if (a == SD_STATUS) return (m_ovr ? 4 : 0) + (m_pend ? 2 : 0) + (sd_busy ? 1 : 0);
    if (a == SD_SECTOR) return m_sec[m_ptr];
    if (a == SD_MODE)   return m_mode;
    if (a == SD_ARGP)   return m_ptr;
    if (a == 8'h38 + MMU_BANKS) return m_en;
    for (int i = 0; i < MMU_BANKS; i++) if (a == 8'h38 + i) return m_mmu[i];
    for (int i = 0; i < GPU_BYTES; i++) if (a == 8'hFC + i) return m_gpu[i];
    return 255;
  endfunction

  function automatic int wd(input logic [7:0] p);
    return int'(bus.WRITE_PORT_DATA[p]);
  endfunction

  task automatic m_step();
    int  old_ptr;
    bit  old_pend, old_op, rd_adv, issue;
    logic [0:255] stb;
    stb      = bus.WRITE_PORT_STROBE;
    old_ptr  = m_ptr;
    old_pend = m_pend;
    old_op   = m_op;
    rd_adv   = RB && bus.READ_PORT_STROBE && (bus.READ_PORT_ADDR == SD_SECTOR);
    if (RB) begin
      m_rvalid = bus.READ_PORT_STROBE;
      if (bus.READ_PORT_STROBE) m_rdata = m_read(int'(bus.READ_PORT_ADDR));
    end
    for (int i = 0; i < MMU_BANKS; i++) if (stb[8'h38 + i]) m_mmu[i] = wd(8'(8'h38 + i));
    if (stb[8'h38 + MMU_BANKS]) m_en = wd(8'(8'h38 + MMU_BANKS));
    for (int i = 0; i < GPU_BYTES; i++) if (stb[8'hFC + i]) m_gpu[i] = wd(8'(8'hFC + i));
    if (stb[SD_STATUS] && ((wd(SD_STATUS) & 4) != 0)) m_ovr = 0;
    issue = 0;
    if (stb[SD_MODE]) begin
      m_mode = wd(SD_MODE) % 4;
      if (!sd_busy && !old_pend && !old_op) issue = 1;
      else begin
        if (old_pend) m_ovr = 1;
        m_pend = 1;
      end
    end else if (old_pend && !sd_busy && !old_op) begin
      issue  = 1;
      m_pend = 0;
    end
    m_op = issue;
    if (stb[SD_SECTOR]) m_sec[old_ptr] = wd(SD_SECTOR);
    if (stb[SD_ARGP]) m_ptr = wd(SD_ARGP) % ARG_BYTES;
    else if (stb[SD_SECTOR] || rd_adv) m_ptr = (old_ptr + 1) % ARG_BYTES;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) m_reset();
    else m_step();
  end

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    logic [0:MMU_BANKS-1][7:0] e_mmu;
    logic [0:GPU_BYTES-1][7:0] e_gpu;
    logic [31:0]               e_sec;
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < MMU_BANKS; i++) e_mmu[i] = 8'(m_mmu[i]);
      for (int i = 0; i < GPU_BYTES; i++) e_gpu[i] = 8'(m_gpu[i]);
      for (int i = 0; i < ARG_BYTES; i++) e_sec[i*8 +: 8] = 8'(m_sec[i]);
      check("mmu_area",   64'(mmu_area),   64'(e_mmu));
      check("mmu_enable", 64'(mmu_enable), 64'(m_en));
      check("gpu_mmu",    64'(gpu_mmu),    64'(e_gpu));
      check("arg_ptr",    64'(arg_ptr),    64'(m_ptr));
      check("sd_sector",  64'(sd_sector),  64'(e_sec));
      check("sd_wr_ena",  64'(sd_wr_ena),  64'(m_mode));
      check("sd_op_ena",  64'(sd_op_ena),  64'(m_op));
      check("sd_pending", 64'(sd_pending), 64'(m_pend));
      check("sd_overrun", 64'(sd_overrun), 64'(m_ovr));
      check("rd_data",    64'(bus.READ_PORT_DATA),  64'(m_rdata));
      check("rd_valid",   64'(bus.READ_PORT_VALID), 64'(m_rvalid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    bus.WRITE_PORT_STROBE[p] = 1'b1;
    bus.WRITE_PORT_DATA[p]   = d;
    tick();
    bus.WRITE_PORT_STROBE = '0;
  endtask

  task automatic rd(input logic [7:0] a);
    bus.READ_PORT_ADDR   = a;
    bus.READ_PORT_STROBE = 1'b1;
    tick();
    bus.READ_PORT_STROBE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sd_busy = 1'b0;
    bus.WRITE_PORT_DATA   = '0;
    bus.WRITE_PORT_STROBE = '0;
    bus.READ_PORT_ADDR    = '0;
    bus.READ_PORT_STROBE  = 1'b0;
    repeat (2) tick();
    started = 1'b1;
    check("reset_mmu_area", 64'(mmu_area), 64'h00000000FF010203);
    check("reset_regs_a", {mmu_enable, gpu_mmu, arg_ptr, sd_wr_ena}, 64'h0);
    check("reset_regs_b", {sd_sector, sd_op_ena, sd_pending, sd_overrun,
                           bus.READ_PORT_DATA, bus.READ_PORT_VALID}, 64'h0);
    reset_n = 1'b1;
    tick();

    // Three registers written in the same cycle.
    bus.WRITE_PORT_STROBE[8'h38] = 1'b1; bus.WRITE_PORT_DATA[8'h38] = 8'h10;
    bus.WRITE_PORT_STROBE[8'h3C] = 1'b1; bus.WRITE_PORT_DATA[8'h3C] = 8'h01;
    bus.WRITE_PORT_STROBE[8'hFD] = 1'b1; bus.WRITE_PORT_DATA[8'hFD] = 8'h0A;
    tick();
    bus.WRITE_PORT_STROBE = '0;
    check("simul_mmu0", 64'(mmu_area), 64'h10010203);
    check("simul_en",   64'(mmu_enable), 64'h01);
    check("simul_gpu",  64'(gpu_mmu), 64'h000A);

    // Sector fill with pointer wrap.
    wr(SD_SECTOR, 8'h11); wr(SD_SECTOR, 8'h22); wr(SD_SECTOR, 8'h33);
    wr(SD_SECTOR, 8'h44); wr(SD_SECTOR, 8'h55);
    check("fill_sector", 64'(sd_sector), 64'h44332255);
    check("fill_ptr",    64'(arg_ptr), 64'd1);

    // Immediate SD operation.
    wr(SD_MODE, 8'h01);
    check("imm_op",   64'(sd_op_ena), 64'd1);
    check("imm_mode", 64'(sd_wr_ena), 64'd1);
    tick();
    check("imm_op_drop", 64'(sd_op_ena), 64'd0);

    // Queued SD operation released when busy drops.
    sd_busy = 1'b1;
    wr(SD_MODE, 8'h02);
    check("q_pending", {sd_pending, sd_op_ena}, 64'b10);
    repeat (2) tick();
    check("q_hold", {sd_pending, sd_op_ena}, 64'b10);
    sd_busy = 1'b0;
    tick();
    check("q_issue", {sd_pending, sd_op_ena, sd_wr_ena}, 64'b0110);
    tick();
    check("q_issue_drop", 64'(sd_op_ena), 64'd0);

    // Overrun, status read-back and clear.
    sd_busy = 1'b1;
    wr(SD_MODE, 8'h01);
    wr(SD_MODE, 8'h02);
    check("ovr_set", {sd_overrun, sd_pending}, 64'b11);
    rd(SD_STATUS);
    if (RB) check("ovr_status", {bus.READ_PORT_VALID, bus.READ_PORT_DATA}, 64'h107);
    else    check("ovr_status_off", {bus.READ_PORT_VALID, bus.READ_PORT_DATA}, 64'h000);
    wr(SD_STATUS, 8'h04);
    check("ovr_clear", {sd_overrun, sd_pending}, 64'b01);
    sd_busy = 1'b0;
    tick();
    check("ovr_issue", {sd_op_ena, sd_pending}, 64'b10);
    tick();

    // Sector read-back with pointer advance.
    wr(SD_ARGP, 8'h00);
    wr(SD_SECTOR, 8'hDD); wr(SD_SECTOR, 8'hCC); wr(SD_SECTOR, 8'hBB); wr(SD_SECTOR, 8'hAA);
    wr(SD_ARGP, 8'h06);
    check("rb_setup", {sd_sector, 6'b0, arg_ptr}, 64'hAABBCCDD02);
    rd(SD_SECTOR);
    if (RB) check("rb_sector", {bus.READ_PORT_VALID, bus.READ_PORT_DATA, 6'b0, arg_ptr}, 64'h1BB03);
    else    check("rb_sector_off", {bus.READ_PORT_VALID, bus.READ_PORT_DATA, 6'b0, arg_ptr}, 64'h00002);
    rd(8'h80);
    if (RB) check("rb_unmapped", {bus.READ_PORT_VALID, bus.READ_PORT_DATA}, 64'h1FF);
    else    check("rb_unmapped_off", {bus.READ_PORT_VALID, bus.READ_PORT_DATA}, 64'h000);
    tick();

    // ARG_PTR and SECTOR written together: byte at old pointer, pointer loaded.
    bus.WRITE_PORT_STROBE[SD_ARGP]   = 1'b1; bus.WRITE_PORT_DATA[SD_ARGP]   = 8'h00;
    bus.WRITE_PORT_STROBE[SD_SECTOR] = 1'b1; bus.WRITE_PORT_DATA[SD_SECTOR] = 8'h5A;
    tick();
    bus.WRITE_PORT_STROBE = '0;
    check("argp_sector", {sd_sector, 6'b0, arg_ptr}, RB ? 64'h5ABBCCDD00 : 64'hAA5ACCDD00);

    // SECTOR read and write in the same cycle: one advance, old byte returned.
    bus.WRITE_PORT_STROBE[SD_SECTOR] = 1'b1; bus.WRITE_PORT_DATA[SD_SECTOR] = 8'h77;
    rd(SD_SECTOR);
    bus.WRITE_PORT_STROBE = '0;
    check("rw_sector", {sd_sector[7:0], 6'b0, arg_ptr}, 64'h7701);
    if (RB) check("rw_sector_data", 64'(bus.READ_PORT_DATA), 64'hDD);

    // Reset while a request is queued.
    sd_busy = 1'b1;
    wr(SD_MODE, 8'h01);
    check("mid_pend", 64'(sd_pending), 64'd1);
    #1 reset_n = 1'b0;
    #1 check("mid_reset_pend", {sd_pending, sd_op_ena}, 64'b00);
    check("mid_reset_mmu", 64'(mmu_area), 64'hFF010203);
    tick();
    reset_n = 1'b1;
    sd_busy = 1'b0;
    repeat (3) tick();
    check("mid_no_issue", 64'(sd_op_ena), 64'd0);

    // Reset during an op pulse.
    wr(SD_MODE, 8'h02);
    check("pulse_high", 64'(sd_op_ena), 64'd1);
    #1 reset_n = 1'b0;
    #1 check("pulse_reset", {sd_op_ena, sd_wr_ena}, 64'b000);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
